// File: rtl/iob_fifo2axis.sv
// Read-side adapter that turns an async FIFO pull port into a valid/ready stream with a 2-entry prefetch buffer.
// Optional beat/packet counters are compiled in when IOB_FIFO2AXIS_STATS_EN is defined.
module iob_fifo2axis #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [LEN_W-1:0]  len,
    input  logic              fifo_empty,
    output logic              fifo_read,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
`ifdef IOB_FIFO2AXIS_STATS_EN
    input  logic              stats_clr,
    output logic [31:0]       beat_total,
    output logic [31:0]       pkt_total,
`endif
    output logic              busy
);

    localparam int unsigned OCC_W  = 2;
    localparam int unsigned DEPTH  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [OCC_W-1:0]   occ;
    logic               inflight;
    logic [DATA_W-1:0]  head_q;
    logic [DATA_W-1:0]  tail_q;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   last_idx;
    logic [OCC_W-1:0]   level;
    logic               xfer;

    // Stream handshake and packet boundary
    assign m_valid  = (occ != OCC_W'(0));
    assign m_data   = head_q;
    assign xfer     = m_valid & m_ready;
    assign last_idx = (len == LEN_W'(0)) ? LEN_W'(0) : (len - LEN_W'(1));
    assign m_last   = m_valid & (cnt == last_idx);

    // A beat leaving this cycle frees its slot, so a read may be issued into it for full throughput
    assign level     = occ + OCC_W'(inflight) - OCC_W'(xfer);
    assign fifo_read = rst_n & en & ~fifo_empty & (level < OCC_W'(DEPTH));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (!en) begin
                    state_nxt = ((occ != OCC_W'(0)) || inflight) ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (en) begin
                    state_nxt = ST_RUN;
                end else if ((occ == OCC_W'(0)) && !inflight) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Prefetch buffer: the read issued last cycle lands at the tail, the head feeds the stream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            occ      <= OCC_W'(0);
            head_q   <= DATA_W'(0);
            tail_q   <= DATA_W'(0);
        end else begin
            inflight <= fifo_read;
            case ({inflight, xfer})
                2'b10: begin
                    if (occ == OCC_W'(0)) begin
                        head_q <= fifo_data;
                    end else begin
                        tail_q <= fifo_data;
                    end
                    occ <= occ + OCC_W'(1);
                end
                2'b01: begin
                    head_q <= tail_q;
                    occ    <= occ - OCC_W'(1);
                end
                2'b11: begin
                    if (occ == OCC_W'(1)) begin
                        head_q <= fifo_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= fifo_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Beat counter within the current packet; survives en toggling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= LEN_W'(0);
        end else if (xfer) begin
            cnt <= m_last ? LEN_W'(0) : (cnt + LEN_W'(1));
        end
    end

`ifdef IOB_FIFO2AXIS_STATS_EN
    // Free-running traffic counters, clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_total <= 32'd0;
            pkt_total  <= 32'd0;
        end else if (stats_clr) begin
            beat_total <= 32'd0;
            pkt_total  <= 32'd0;
        end else if (xfer) begin
            beat_total <= beat_total + 32'd1;
            if (m_last) begin
                pkt_total <= pkt_total + 32'd1;
            end
        end
    end
`endif

endmodule
